// File: rtl/quant_output_packer_pkg.sv
// quant_output_packer_pkg: shared widths, output_bits encodings and packer states.
package quant_output_packer_pkg;
  localparam int DATA_WIDTH = 32;
  localparam logic [1:0] OBITS_8 = 2'd0;
  localparam logic [1:0] OBITS_16 = 2'd1;
  localparam logic [1:0] OBITS_32 = 2'd2;
  typedef enum logic {PACK_IDLE, PACK_FILL} pack_state_e;
  function automatic logic [1:0] obits_norm(input logic [1:0] ob);
    return (ob == OBITS_8 || ob == OBITS_16) ? ob : OBITS_32;
  endfunction
endpackage

// File: rtl/quant_lane_sat.sv
// quant_lane_sat: clamp (QUANT_PACK_SATURATE_EN) or truncate one element to the lane width,
// result zero-extended in the low bits.
module quant_lane_sat
  import quant_output_packer_pkg::*;
(
  input  logic [DATA_WIDTH-1:0] din,
  input  logic [1:0]            wsel,
`ifdef QUANT_PACK_SATURATE_EN
  output logic                  sat,
`endif
  output logic [DATA_WIDTH-1:0] lane
);
`ifdef QUANT_PACK_SATURATE_EN
  logic signed [DATA_WIDTH-1:0] s;
  logic hi8, lo8, hi16, lo16;
  assign s = $signed(din);
  assign hi8 = s > 127;
  assign lo8 = s < -128;
  assign hi16 = s > 32767;
  assign lo16 = s < -32768;
  always_comb begin
    sat = 1'b0;
    lane = din;
    if (wsel == OBITS_8) begin
      sat = hi8 || lo8;
      lane = hi8 ? DATA_WIDTH'(8'h7F) : lo8 ? DATA_WIDTH'(8'h80) : DATA_WIDTH'(din[7:0]);
    end else if (wsel == OBITS_16) begin
      sat = hi16 || lo16;
      lane = hi16 ? DATA_WIDTH'(16'h7FFF) : lo16 ? DATA_WIDTH'(16'h8000) : DATA_WIDTH'(din[15:0]);
    end
  end
`else
  always_comb
    lane = (wsel == OBITS_8) ? DATA_WIDTH'(din[7:0]) :
           (wsel == OBITS_16) ? DATA_WIDTH'(din[15:0]) : din;
`endif
endmodule

// File: rtl/quant_output_packer.sv
// quant_output_packer: packs 8/16/32-bit quantized elements into words with byte enables.
// Optional QUANT_PACK_SATURATE_EN clamps elements to the lane range and adds sat_flag.
module quant_output_packer
  import quant_output_packer_pkg::pack_state_e;
  import quant_output_packer_pkg::PACK_IDLE;
  import quant_output_packer_pkg::PACK_FILL;
  import quant_output_packer_pkg::OBITS_8;
  import quant_output_packer_pkg::OBITS_16;
  import quant_output_packer_pkg::obits_norm;
#(
  parameter int DATA_WIDTH = quant_output_packer_pkg::DATA_WIDTH,
  parameter int BE_WIDTH = DATA_WIDTH / 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  valid_in,
  output logic                  ready_in,
  input  logic                  last_in,
  input  logic [1:0]            output_bits,
  input  logic                  flush,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic [BE_WIDTH-1:0]   byte_en,
  output logic                  valid_out,
  input  logic                  ready_out,
  output logic                  last_out,
`ifdef QUANT_PACK_SATURATE_EN
  output logic                  sat_flag,
`endif
  output logic                  busy
);
  pack_state_e state, state_n;
  logic [1:0] lane_idx, lane_idx_n, wsel_cur, w_eff, last_lane;
  logic [DATA_WIDTH-1:0] acc, acc_n, acc_upd, lane;
  logic [BE_WIDTH-1:0] mask, mask_n, mask_upd, lane_be;
  logic [4:0] sh;
  logic [2:0] boff;
  logic pend_flush, pend_n, accept, complete, flush_emit, load;
`ifdef QUANT_PACK_SATURATE_EN
  logic sat;
`endif
  assign ready_in = !valid_out || ready_out;
  assign accept = valid_in && ready_in;
  // Width is taken fresh only at the start of a word; mid-word changes are ignored.
  assign w_eff = (lane_idx == 2'd0) ? obits_norm(output_bits) : wsel_cur;
  assign last_lane = (w_eff == OBITS_8) ? 2'd3 : (w_eff == OBITS_16) ? 2'd1 : 2'd0;
  assign complete = accept && (lane_idx == last_lane || last_in);
  assign flush_emit = state == PACK_FILL && !accept && ready_in && (pend_flush || flush);
  assign load = complete || flush_emit;
  assign sh = {lane_idx, 3'b000} << w_eff;
  assign boff = {1'b0, lane_idx} << w_eff;
  assign lane_be = (w_eff == OBITS_8) ? BE_WIDTH'(1) : (w_eff == OBITS_16) ? BE_WIDTH'(3) : '1;
  assign acc_upd = acc | (lane << sh);
  assign mask_upd = mask | (lane_be << boff);
  assign busy = state == PACK_FILL || valid_out || pend_flush;
  quant_lane_sat u_sat (
    .din  (data_in),
    .wsel (w_eff),
`ifdef QUANT_PACK_SATURATE_EN
    .sat  (sat),
`endif
    .lane (lane)
  );
  always_comb begin
    state_n = state;
    acc_n = acc;
    mask_n = mask;
    lane_idx_n = lane_idx;
    pend_n = pend_flush || flush;
    if (complete || flush_emit) begin
      state_n = PACK_IDLE;
      acc_n = '0;
      mask_n = '0;
      lane_idx_n = 2'd0;
      pend_n = 1'b0;
    end else if (accept) begin
      state_n = PACK_FILL;
      acc_n = acc_upd;
      mask_n = mask_upd;
      lane_idx_n = lane_idx + 2'd1;
    end else if (state == PACK_IDLE) begin
      pend_n = 1'b0;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= PACK_IDLE;
      acc <= '0;
      mask <= '0;
      lane_idx <= 2'd0;
      wsel_cur <= OBITS_8;
      pend_flush <= 1'b0;
    end else begin
      state <= state_n;
      acc <= acc_n;
      mask <= mask_n;
      lane_idx <= lane_idx_n;
      pend_flush <= pend_n;
      if (accept && lane_idx == 2'd0) wsel_cur <= w_eff;
    end
  end
  // A load only happens when ready_in is high, so a held word is never overwritten.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_out <= '0;
      byte_en <= '0;
      valid_out <= 1'b0;
      last_out <= 1'b0;
    end else if (load) begin
      data_out <= complete ? acc_upd : acc;
      byte_en <= complete ? mask_upd : mask;
      valid_out <= 1'b1;
      last_out <= complete && last_in;
    end else if (ready_out) begin
      valid_out <= 1'b0;
      last_out <= 1'b0;
    end
  end
`ifdef QUANT_PACK_SATURATE_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sat_flag <= 1'b0;
    else sat_flag <= accept && sat;
  end
`endif
endmodule

// File: tb/tb_quant_output_packer.sv
// tb_quant_output_packer: directed self-checking bench for quant_output_packer.
module tb_quant_output_packer;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [31:0] data_in = '0;
  logic valid_in = 1'b0;
  logic ready_in;
  logic last_in = 1'b0;
  logic [1:0] output_bits = 2'd0;
  logic flush = 1'b0;
  logic [31:0] data_out;
  logic [3:0] byte_en;
  logic valid_out;
  logic ready_out = 1'b1;
  logic last_out;
  logic busy;
`ifdef QUANT_PACK_SATURATE_EN
  logic sat_flag;
`endif
  int vectors = 0;
  int miscompares = 0;

  quant_output_packer dut (
    .clk(clk), .rst_n(rst_n), .data_in(data_in), .valid_in(valid_in), .ready_in(ready_in),
    .last_in(last_in), .output_bits(output_bits), .flush(flush), .data_out(data_out),
    .byte_en(byte_en), .valid_out(valid_out), .ready_out(ready_out), .last_out(last_out),
`ifdef QUANT_PACK_SATURATE_EN
    .sat_flag(sat_flag),
`endif
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] d, input logic l);
    data_in = d;
    last_in = l;
    valid_in = 1'b1;
    tick();
    valid_in = 1'b0;
    last_in = 1'b0;
  endtask

  task automatic pulse_flush_wait();
    int n;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    n = 0;
    while (!valid_out && n < 4) begin
      tick();
      n++;
    end
    check("flush_valid", valid_out, 1);
  endtask

  initial begin
    int sent, got;
    logic held, acc;
    logic [31:0] hd;
    #3;
    check("rst_data", data_out, 0);
    check("rst_be", byte_en, 0);
    check("rst_valid", valid_out, 0);
    check("rst_last", last_out, 0);
    check("rst_busy", busy, 0);
    check("rst_ready", ready_in, 1);
    #10 rst_n = 1'b1;
    tick();

    output_bits = 2'd0;
    send(32'h11, 0);
    send(32'h22, 0);
    send(32'h33, 0);
    check("b8_early", valid_out, 0);
    send(32'h44, 0);
    check("b8_valid", valid_out, 1);
    check("b8_data", data_out, 32'h44332211);
    check("b8_be", byte_en, 4'hF);
    check("b8_last", last_out, 0);
    tick();
    check("b8_drop", valid_out, 0);
    check("b8_idle", busy, 0);

    output_bits = 2'd1;
    send(32'hAAAA, 0);
    send(32'hBBBB, 1);
    check("b16_valid", valid_out, 1);
    check("b16_data", data_out, 32'hBBBBAAAA);
    check("b16_be", byte_en, 4'hF);
    check("b16_last", last_out, 1);
    send(32'hCCCC, 0);
    check("b16_partial_novalid", valid_out, 0);
    check("b16_partial_busy", busy, 1);
    pulse_flush_wait();
    check("b16_fl_data", data_out, 32'h0000CCCC);
    check("b16_fl_be", byte_en, 4'h3);
    check("b16_fl_last", last_out, 0);
    tick();
    check("b16_fl_drop", valid_out, 0);
    check("b16_fl_idle", busy, 0);

    output_bits = 2'd0;
    send(32'h01, 0);
    send(32'h02, 0);
    send(32'h03, 0);
    pulse_flush_wait();
    check("b8_fl_data", data_out, 32'h00030201);
    check("b8_fl_be", byte_en, 4'h7);
    tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("idle_fl_novalid", valid_out, 0);
    tick();
    check("idle_fl_novalid2", valid_out, 0);
    check("idle_fl_busy", busy, 0);

    output_bits = 2'd2;
    sent = 0;
    got = 0;
    for (int c = 0; c < 60 && got < 8; c++) begin
      ready_out = (c % 2 == 0);
      valid_in = (sent < 8);
      data_in = 32'hA000_0000 + sent;
      #1;
      check("rdy_eq", ready_in, !valid_out || ready_out);
      if (valid_out && ready_out) begin
        check("stream_data", data_out, 32'hA000_0000 + got);
        check("stream_be", byte_en, 4'hF);
        got++;
      end
      held = valid_out && !ready_out;
      hd = data_out;
      acc = valid_in && ready_in;
      tick();
      if (acc) sent++;
      if (held) begin
        check("stall_valid", valid_out, 1);
        check("stall_data", data_out, hd);
      end
    end
    valid_in = 1'b0;
    ready_out = 1'b1;
    check("stream_count", got, 8);
    tick();
    check("stream_drain", valid_out, 0);

    output_bits = 2'd0;
    send(32'hE1, 0);
    send(32'hE2, 0);
    check("pre_rst_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", valid_out, 0);
    check("mid_rst_data", data_out, 0);
    check("mid_rst_busy", busy, 0);
    #3 rst_n = 1'b1;
    tick();
    send(32'h55, 0);
    send(32'h66, 0);
    send(32'h77, 0);
    send(32'h88, 0);
    check("post_rst_valid", valid_out, 1);
    check("post_rst_data", data_out, 32'h88776655);
    check("post_rst_be", byte_en, 4'hF);
    tick();

`ifdef QUANT_PACK_SATURATE_EN
    output_bits = 2'd0;
    send(32'd300, 0);
    check("sat_300", sat_flag, 1);
    send(-32'sd200, 0);
    check("sat_m200", sat_flag, 1);
    send(32'd5, 0);
    check("sat_5", sat_flag, 0);
    send(32'hFFFF_FFFF, 0);
    check("sat_m1", sat_flag, 0);
    check("sat_data", data_out, 32'hFF05807F);
    check("sat_valid", valid_out, 1);
    tick();
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
